storage_rw_arbiter: RTL and testbench
=====================================

// Module: storage_rw_arbiter
// PURPOSE
//   Shares the single management R/W port of the storage block (RAM_BLOCKS SRAM banks) between two
//   Wishbone slave requesters: port A (management CPU) and port B (housekeeping/DMA master).
//   Sits between mgmt_core and storage on the mgmt_ena/mgmt_wen/mgmt_addr/mgmt_wdata/mgmt_rdata bus.
//   Sequences each access through a small FSM and fixes SRAM timing. Round-robin arbitration between A and B.
// PARAMETERS
//   RAM_BLOCKS  2  number of SRAM banks behind the port; 1..8
//   ADDR_W      8  word-address width per bank
//   BANK_W      1  bank-select width, clog2(RAM_BLOCKS), minimum 1
// PORTS
//   core_clk       in   1                single clock; all logic on rising edge
//   core_rst       in   1                synchronous reset, active-high
//   a_cyc_i/a_stb_i/a_we_i in 1 each     port A Wishbone request
//   a_sel_i        in   4                port A byte enables
//   a_adr_i        in   32               port A byte address
//   a_dat_i        in   32               port A write data
//   a_dat_o        out  32               port A read data, valid while a_ack_o
//   a_ack_o        out  1                port A one-cycle acknowledge
//   b_*            -    -                port B, identical set to port A
//   mgmt_ena       out  RAM_BLOCKS       per-bank enable, one-hot or zero
//   mgmt_wen       out  RAM_BLOCKS       per-bank write enable, subset of mgmt_ena
//   mgmt_wen_mask  out  RAM_BLOCKS*4     per-bank byte mask; bank k uses bits [4k+3:4k]
//   mgmt_addr      out  ADDR_W           word address
//   mgmt_wdata     out  32               write data
//   mgmt_rdata     in   RAM_BLOCKS*32    per-bank read data; valid in the cycle after the enabled edge
//   busy           out  1                FSM not IDLE
// BEHAVIOUR
//   - Reset: FSM=IDLE; every output 0; last_grant=B, so A wins the first contention.
//   - All outputs are registered.
//   - Request: port X requests when x_cyc_i & x_stb_i.
//   - Address decode:
//       word address = adr[ADDR_W+1:2]
//       bank         = adr[ADDR_W+2 +: BANK_W]
//       adr bits above the bank field are ignored
//   - Arbitration, IDLE only:
//       only one port requesting -> that port wins
//       both requesting          -> the port != last_grant wins
//       last_grant updates on every grant
//   - Winner's we, sel, adr and dat are latched; the FSM ignores live port inputs until the next IDLE.
//   - FSM states:
//       IDLE  -> ISSUE on any request. At this edge mgmt_ena[bank], mgmt_addr and mgmt_wdata are set.
//                For a write, mgmt_wen[bank] and the mask slice are also set (mask = sel).
//       ISSUE -> ACK when write; ack is registered high for the winner.
//       ISSUE -> RDATA when read.
//       All SRAM controls clear when leaving ISSUE, so ena is high for exactly one cycle.
//       RDATA -> ACK. At this edge x_dat_o <= mgmt_rdata[bank*32 +: 32] and x_ack_o <= 1.
//       ACK   -> IDLE. At this edge ack and dat_o clear to 0.
//   - Latency, with the request sampled at edge N:
//       write: ack high in the cycle after edge N+1
//       read:  ack high in the cycle after edge N+2
//       earliest next grant: edge N+3 (write) or N+4 (read)
//   - Exactly one ack pulse per granted access, never to the losing port.
//   - The loser keeps waiting with its stb held and is served next.
//   - Bank >= RAM_BLOCKS (non-power-of-2 config): no ena/wen is asserted.
//     The access still follows the FSM and acks; read data = 32'h0.
//   - Write with sel == 0: wen still pulses, mask = 0 (no byte changes); ack as normal.
//   - cyc dropped after grant: the SRAM access completes, but ack and dat_o are suppressed.
//     The FSM still passes through ACK to IDLE.
//   - core_rst mid-access: next edge forces IDLE and all outputs 0. No partial ack.
//     A write whose ISSUE edge has already passed is not rolled back.
//   - busy = (state != IDLE).
// TESTING
//   1. Write, port A only: A writes 0xDEADBEEF, sel=4'hF, adr=0x0000_0104.
//      -> ena[0] and wen[0] high for 1 cycle, addr=0x41, mask[3:0]=F; a_ack 1 cycle later.
//   2. Read-back on A, same address -> a_ack in the 3rd cycle after request, a_dat_o=0xDEADBEEF.
//   3. Contention: A and B request in the same cycle, twice in a row.
//      -> A is served, then B; on the next simultaneous request A again. Strict alternation, no lost acks.
//   4. Bank select: B writes sel=4'b0010, adr bank bit=1 (RAM_BLOCKS=2).
//      -> only ena[1]/wen[1] pulse, mask[7:4]=4'b0010, mask[3:0]=0.
//   5. Abort: A read granted, a_cyc_i dropped in ISSUE -> no a_ack; busy falls after ACK; B then granted normally.
//   6. Reset: core_rst pulsed in RDATA state -> next cycle all outputs 0, FSM IDLE.
//      The next A request is then granted first.

Source files
------------

// File: rtl/storage_rw_arbiter.sv
// Round-robin arbiter sharing the storage management R/W port between Wishbone ports A and B.
// Write acks 2 cycles after the request, read 3; the losing port holds stb and is served next.
module storage_rw_arbiter #(
  parameter int RAM_BLOCKS = 2,
  parameter int ADDR_W     = 8,
  parameter int BANK_W     = 1
) (
  input  logic                     core_clk,
  input  logic                     core_rst,
  input  logic                     a_cyc_i,
  input  logic                     a_stb_i,
  input  logic                     a_we_i,
  input  logic [3:0]               a_sel_i,
  input  logic [31:0]              a_adr_i,
  input  logic [31:0]              a_dat_i,
  output logic [31:0]              a_dat_o,
  output logic                     a_ack_o,
  input  logic                     b_cyc_i,
  input  logic                     b_stb_i,
  input  logic                     b_we_i,
  input  logic [3:0]               b_sel_i,
  input  logic [31:0]              b_adr_i,
  input  logic [31:0]              b_dat_i,
  output logic [31:0]              b_dat_o,
  output logic                     b_ack_o,
  output logic [RAM_BLOCKS-1:0]    mgmt_ena,
  output logic [RAM_BLOCKS-1:0]    mgmt_wen,
  output logic [RAM_BLOCKS*4-1:0]  mgmt_wen_mask,
  output logic [ADDR_W-1:0]        mgmt_addr,
  output logic [31:0]              mgmt_wdata,
  input  logic [RAM_BLOCKS*32-1:0] mgmt_rdata,
  output logic                     busy
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_RDATA, S_ACK} state_t;

  state_t                  r_state, w_state_nxt;
  logic                    w_a_req, w_b_req, w_req, w_gnt_b;
  logic                    w_we, w_cyc_live, w_drop, w_ack_nxt;
  logic [3:0]              w_sel;
  logic [31:0]             w_adr, w_dat, w_rdata, w_dat_nxt;
  logic [BANK_W-1:0]       w_bank, r_bank;
  logic                    r_gnt_b, r_last_b, r_we, r_abort;
  logic [RAM_BLOCKS-1:0]   r_ena, r_wen, w_ena_nxt, w_wen_nxt;
  logic [RAM_BLOCKS*4-1:0] r_mask, w_mask_nxt;
  logic [ADDR_W-1:0]       r_addr, w_addr_nxt;
  logic [31:0]             r_wdata, w_wdata_nxt, r_a_dat, r_b_dat;
  logic                    r_a_ack, r_b_ack;
  logic                    w_unused_adr;

  assign w_a_req = a_cyc_i & a_stb_i;
  assign w_b_req = b_cyc_i & b_stb_i;
  assign w_req   = w_a_req | w_b_req;
  // B wins only when alone, or when A was the last port served
  assign w_gnt_b = w_b_req & (~w_a_req | ~r_last_b);

  assign w_we   = w_gnt_b ? b_we_i  : a_we_i;
  assign w_sel  = w_gnt_b ? b_sel_i : a_sel_i;
  assign w_adr  = w_gnt_b ? b_adr_i : a_adr_i;
  assign w_dat  = w_gnt_b ? b_dat_i : a_dat_i;
  assign w_bank = w_adr[ADDR_W+2 +: BANK_W];

  assign w_cyc_live   = r_gnt_b ? b_cyc_i : a_cyc_i;
  assign w_drop       = r_abort | ~w_cyc_live;
  assign w_unused_adr = ^{a_adr_i, b_adr_i};

  // Out-of-range banks read back as zero
  always_comb begin
    w_rdata = '0;
    for (int k = 0; k < RAM_BLOCKS; k++) begin
      if (r_bank == BANK_W'(k)) w_rdata = mgmt_rdata[32*k +: 32];
    end
  end

  always_ff @(posedge core_clk) begin
    if (core_rst) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_req) w_state_nxt = S_ISSUE;
      S_ISSUE: w_state_nxt = r_we ? S_ACK : S_RDATA;
      S_RDATA: w_state_nxt = S_ACK;
      S_ACK:   w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    w_ena_nxt   = '0;
    w_wen_nxt   = '0;
    w_mask_nxt  = '0;
    w_addr_nxt  = '0;
    w_wdata_nxt = '0;
    w_ack_nxt   = 1'b0;
    w_dat_nxt   = '0;
    case (r_state)
      S_IDLE: begin
        if (w_req) begin
          w_addr_nxt  = w_adr[ADDR_W+1:2];
          w_wdata_nxt = w_dat;
          for (int k = 0; k < RAM_BLOCKS; k++) begin
            if (w_bank == BANK_W'(k)) begin
              w_ena_nxt[k] = 1'b1;
              w_wen_nxt[k] = w_we;
              if (w_we) w_mask_nxt[4*k +: 4] = w_sel;
            end
          end
        end
      end
      S_ISSUE: w_ack_nxt = r_we & ~w_drop;
      S_RDATA: begin
        w_ack_nxt = ~w_drop;
        if (!w_drop) w_dat_nxt = w_rdata;
      end
      default: ;
    endcase
  end

  always_ff @(posedge core_clk) begin
    if (core_rst) begin
      r_ena    <= '0;
      r_wen    <= '0;
      r_mask   <= '0;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_a_ack  <= 1'b0;
      r_b_ack  <= 1'b0;
      r_a_dat  <= '0;
      r_b_dat  <= '0;
      r_gnt_b  <= 1'b0;
      r_last_b <= 1'b1;
      r_we     <= 1'b0;
      r_bank   <= '0;
      r_abort  <= 1'b0;
    end else begin
      r_ena   <= w_ena_nxt;
      r_wen   <= w_wen_nxt;
      r_mask  <= w_mask_nxt;
      r_addr  <= w_addr_nxt;
      r_wdata <= w_wdata_nxt;
      r_a_ack <= w_ack_nxt & ~r_gnt_b;
      r_b_ack <= w_ack_nxt & r_gnt_b;
      r_a_dat <= r_gnt_b ? 32'h0 : w_dat_nxt;
      r_b_dat <= r_gnt_b ? w_dat_nxt : 32'h0;
      if (r_state == S_IDLE && w_req) begin
        r_gnt_b  <= w_gnt_b;
        r_last_b <= w_gnt_b;
        r_we     <= w_we;
        r_bank   <= w_bank;
        r_abort  <= 1'b0;
      end else if ((r_state == S_ISSUE || r_state == S_RDATA) && !w_cyc_live) begin
        r_abort <= 1'b1;
      end
    end
  end

  assign mgmt_ena      = r_ena;
  assign mgmt_wen      = r_wen;
  assign mgmt_wen_mask = r_mask;
  assign mgmt_addr     = r_addr;
  assign mgmt_wdata    = r_wdata;
  assign a_ack_o       = r_a_ack;
  assign b_ack_o       = r_b_ack;
  assign a_dat_o       = r_a_dat;
  assign b_dat_o       = r_b_dat;
  assign busy          = (r_state != S_IDLE);

endmodule

// File: tb/tb_storage_rw_arbiter.sv
// Bench for storage_rw_arbiter: directed and random accesses against a word-level memory model.
module tb_storage_rw_arbiter;
  localparam int RB = 2;
  localparam int AW = 8;
  localparam int BW = 1;

  logic          core_clk = 1'b0;
  logic          core_rst;
  logic          a_cyc_i, a_stb_i, a_we_i, b_cyc_i, b_stb_i, b_we_i;
  logic [3:0]    a_sel_i, b_sel_i;
  logic [31:0]   a_adr_i, a_dat_i, b_adr_i, b_dat_i;
  logic [31:0]   a_dat_o, b_dat_o;
  logic          a_ack_o, b_ack_o;
  logic [RB-1:0] mgmt_ena, mgmt_wen;
  logic [RB*4-1:0]  mgmt_wen_mask;
  logic [AW-1:0]    mgmt_addr;
  logic [31:0]      mgmt_wdata;
  logic [RB*32-1:0] mgmt_rdata;
  logic             busy;

  int n_tests = 0;
  int n_fail  = 0;
  bit last_b  = 1'b1;
  logic tb_init;

  logic [31:0] sram    [RB][2**AW];
  logic [31:0] ref_mem [RB][2**AW];

  logic [RB-1:0]   snap_ena, snap_wen, snap2_ena;
  logic [RB*4-1:0] snap_mask;
  logic [AW-1:0]   snap_addr;
  logic [31:0]     snap_wdata;

  always #5 core_clk = ~core_clk;

  storage_rw_arbiter #(.RAM_BLOCKS(RB), .ADDR_W(AW), .BANK_W(BW)) dut (
    .core_clk(core_clk), .core_rst(core_rst),
    .a_cyc_i(a_cyc_i), .a_stb_i(a_stb_i), .a_we_i(a_we_i), .a_sel_i(a_sel_i),
    .a_adr_i(a_adr_i), .a_dat_i(a_dat_i), .a_dat_o(a_dat_o), .a_ack_o(a_ack_o),
    .b_cyc_i(b_cyc_i), .b_stb_i(b_stb_i), .b_we_i(b_we_i), .b_sel_i(b_sel_i),
    .b_adr_i(b_adr_i), .b_dat_i(b_dat_i), .b_dat_o(b_dat_o), .b_ack_o(b_ack_o),
    .mgmt_ena(mgmt_ena), .mgmt_wen(mgmt_wen), .mgmt_wen_mask(mgmt_wen_mask),
    .mgmt_addr(mgmt_addr), .mgmt_wdata(mgmt_wdata), .mgmt_rdata(mgmt_rdata), .busy(busy)
  );

  // SRAM banks: byte-masked write, read data valid the cycle after the enabled edge
  always @(posedge core_clk) begin
    if (tb_init) begin
      mgmt_rdata <= '0;
      for (int k = 0; k < RB; k++)
        for (int w = 0; w < 2**AW; w++) sram[k][w] <= 32'h0;
    end else begin
      for (int k = 0; k < RB; k++) begin
        if (mgmt_ena[k]) begin
          if (mgmt_wen[k]) begin
            for (int j = 0; j < 4; j++)
              if (mgmt_wen_mask[4*k+j]) sram[k][mgmt_addr][8*j +: 8] <= mgmt_wdata[8*j +: 8];
          end else begin
            mgmt_rdata[32*k +: 32] <= sram[k][mgmt_addr];
          end
        end
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
    end
  endtask

  function automatic int bank_of(input logic [31:0] adr);
    return int'((adr >> (AW + 2)) % (2**BW));
  endfunction

  function automatic int word_of(input logic [31:0] adr);
    return int'((adr >> 2) % (2**AW));
  endfunction

  task automatic model_apply(input bit we, input logic [3:0] sel, input logic [31:0] adr,
                             input logic [31:0] dat, output logic [31:0] rd);
    int bk, wd;
    bk = bank_of(adr);
    wd = word_of(adr);
    rd = (bk < RB) ? ref_mem[bk][wd] : 32'h0;
    if (we && bk < RB)
      for (int j = 0; j < 4; j++) if (sel[j]) ref_mem[bk][wd][8*j +: 8] = dat[8*j +: 8];
  endtask

  // Called at a falling edge; presents requests and watches 12 cycles
  task automatic run_pair(input string tag,
      input bit ea, input bit wa, input logic [3:0] sa, input logic [31:0] aa, input logic [31:0] da,
      input bit eb, input bit wb, input logic [3:0] sb, input logic [31:0] ab, input logic [31:0] db);
    bit first_b;
    int exp_a, exp_b, got_a, got_b, cnt_a, cnt_b, g2;
    logic [31:0] rd_a, rd_b, dat_a, dat_b;
    exp_a = -1; exp_b = -1; got_a = -1; got_b = -1; cnt_a = 0; cnt_b = 0;
    rd_a = 32'h0; rd_b = 32'h0; dat_a = 32'h0; dat_b = 32'h0;
    first_b = (ea && eb) ? !last_b : eb;
    if (first_b) begin
      model_apply(wb, sb, ab, db, rd_b);
      exp_b = wb ? 2 : 3;
      g2 = wb ? 4 : 5;
      if (ea) begin model_apply(wa, sa, aa, da, rd_a); exp_a = g2 + (wa ? 1 : 2); end
      last_b = !ea;
    end else begin
      model_apply(wa, sa, aa, da, rd_a);
      exp_a = wa ? 2 : 3;
      g2 = wa ? 4 : 5;
      if (eb) begin model_apply(wb, sb, ab, db, rd_b); exp_b = g2 + (wb ? 1 : 2); end
      last_b = eb;
    end
    a_cyc_i = ea; a_stb_i = ea; a_we_i = wa; a_sel_i = sa; a_adr_i = aa; a_dat_i = da;
    b_cyc_i = eb; b_stb_i = eb; b_we_i = wb; b_sel_i = sb; b_adr_i = ab; b_dat_i = db;
    for (int e = 1; e <= 12; e++) begin
      @(negedge core_clk);
      if (e == 1) begin
        snap_ena = mgmt_ena; snap_wen = mgmt_wen; snap_mask = mgmt_wen_mask;
        snap_addr = mgmt_addr; snap_wdata = mgmt_wdata;
      end
      if (e == 2) snap2_ena = mgmt_ena;
      if (a_ack_o) begin cnt_a++; got_a = e; dat_a = a_dat_o; a_cyc_i = 1'b0; a_stb_i = 1'b0; end
      if (b_ack_o) begin cnt_b++; got_b = e; dat_b = b_dat_o; b_cyc_i = 1'b0; b_stb_i = 1'b0; end
    end
    chk({tag, " a_ack_count"}, 32'(cnt_a), ea ? 32'd1 : 32'd0);
    chk({tag, " b_ack_count"}, 32'(cnt_b), eb ? 32'd1 : 32'd0);
    if (ea) chk({tag, " a_ack_cycle"}, 32'(got_a), 32'(exp_a));
    if (eb) chk({tag, " b_ack_cycle"}, 32'(got_b), 32'(exp_b));
    if (ea && !wa) chk({tag, " a_rdata"}, dat_a, rd_a);
    if (eb && !wb) chk({tag, " b_rdata"}, dat_b, rd_b);
    chk({tag, " idle_after"}, {31'h0, busy}, 32'h0);
  endtask

  function automatic logic [31:0] rand_adr();
    logic [31:0] r;
    r = $urandom;
    return (r & 32'hFFFF_F803) | (32'($urandom_range(1, 0)) << 10) | (32'($urandom_range(7, 0)) << 2);
  endfunction

  task automatic check_all_zero(input string tag);
    chk({tag, " ena"},   32'(mgmt_ena), 32'h0);
    chk({tag, " wen"},   32'(mgmt_wen), 32'h0);
    chk({tag, " mask"},  32'(mgmt_wen_mask), 32'h0);
    chk({tag, " addr"},  32'(mgmt_addr), 32'h0);
    chk({tag, " wdata"}, mgmt_wdata, 32'h0);
    chk({tag, " acks"},  {30'h0, a_ack_o, b_ack_o}, 32'h0);
    chk({tag, " dat_o"}, a_dat_o | b_dat_o, 32'h0);
    chk({tag, " busy"},  {31'h0, busy}, 32'h0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, observed timeout, expected completion");
    $fatal(1);
  end

  initial begin
    int m, cnt, fall;
    tb_init = 1'b1;
    core_rst = 1'b1;
    a_cyc_i = 0; a_stb_i = 0; a_we_i = 0; a_sel_i = 0; a_adr_i = 0; a_dat_i = 0;
    b_cyc_i = 0; b_stb_i = 0; b_we_i = 0; b_sel_i = 0; b_adr_i = 0; b_dat_i = 0;
    for (int k = 0; k < RB; k++)
      for (int w = 0; w < 2**AW; w++) ref_mem[k][w] = 32'h0;
    repeat (3) @(negedge core_clk);
    tb_init = 1'b0;
    check_all_zero("reset");
    core_rst = 1'b0;
    @(negedge core_clk);

    run_pair("t1_write", 1, 1, 4'hF, 32'h0000_0104, 32'hDEAD_BEEF, 0, 0, 4'h0, 32'h0, 32'h0);
    chk("t1 ena",   32'(snap_ena), 32'h1);
    chk("t1 wen",   32'(snap_wen), 32'h1);
    chk("t1 addr",  32'(snap_addr), 32'h41);
    chk("t1 mask",  32'(snap_mask), 32'h0F);
    chk("t1 wdata", snap_wdata, 32'hDEAD_BEEF);
    chk("t1 ena_one_cycle", 32'(snap2_ena), 32'h0);

    run_pair("t2_read", 1, 0, 4'hF, 32'h0000_0104, 32'h0, 0, 0, 4'h0, 32'h0, 32'h0);
    chk("t2 ena", 32'(snap_ena), 32'h1);
    chk("t2 wen", 32'(snap_wen), 32'h0);

    run_pair("t3_cont1", 1, 1, 4'hF, 32'h0000_0010, 32'h1111_1111, 1, 1, 4'hF, 32'h0000_0014, 32'h2222_2222);
    run_pair("t3_cont2", 1, 0, 4'hF, 32'h0000_0014, 32'h0, 1, 0, 4'hF, 32'h0000_0010, 32'h0);

    run_pair("t4_bank", 0, 0, 4'h0, 32'h0, 32'h0, 1, 1, 4'b0010, 32'hA000_0408, 32'h0000_5A00);
    chk("t4 ena",  32'(snap_ena), 32'h2);
    chk("t4 wen",  32'(snap_wen), 32'h2);
    chk("t4 mask", 32'(snap_mask), 32'h20);
    chk("t4 addr", 32'(snap_addr), 32'h02);

    run_pair("sel0_write", 1, 1, 4'h0, 32'h0000_0104, 32'h1234_5678, 0, 0, 4'h0, 32'h0, 32'h0);
    chk("sel0 wen",  32'(snap_wen), 32'h1);
    chk("sel0 mask", 32'(snap_mask), 32'h0);
    run_pair("sel0_read", 1, 0, 4'h0, 32'h0000_0104, 32'h0, 0, 0, 4'h0, 32'h0, 32'h0);

    // Abort: A read with cyc dropped during ISSUE
    a_cyc_i = 1; a_stb_i = 1; a_we_i = 0; a_adr_i = 32'h0000_0104;
    @(negedge core_clk);
    chk("t5 busy_issue", {31'h0, busy}, 32'h1);
    a_cyc_i = 0; a_stb_i = 0;
    cnt = 0; fall = -1;
    for (int e = 2; e <= 7; e++) begin
      @(negedge core_clk);
      if (a_ack_o) cnt++;
      if (!busy && fall < 0) fall = e;
    end
    last_b = 1'b0;
    chk("t5 no_ack", 32'(cnt), 32'h0);
    chk("t5 busy_fall_cycle", 32'(fall), 32'd4);
    run_pair("t5_b_after", 0, 0, 4'h0, 32'h0, 32'h0, 1, 0, 4'hF, 32'h0000_0104, 32'h0);

    // Reset pulsed while a read sits in RDATA
    a_cyc_i = 1; a_stb_i = 1; a_we_i = 0; a_adr_i = 32'h0000_0104;
    repeat (2) @(negedge core_clk);
    chk("t6 busy_rdata", {31'h0, busy}, 32'h1);
    core_rst = 1'b1; a_cyc_i = 0; a_stb_i = 0;
    @(negedge core_clk);
    check_all_zero("t6_reset");
    core_rst = 1'b0;
    last_b = 1'b1;
    @(negedge core_clk);
    run_pair("t6_cont1", 1, 0, 4'hF, 32'h0000_0010, 32'h0, 1, 0, 4'hF, 32'h0000_0014, 32'h0);
    run_pair("t6_cont2", 1, 1, 4'h3, 32'h0000_0018, 32'hCAFE_F00D, 1, 1, 4'hC, 32'h0000_0018, 32'hBEEF_0000);

    for (int i = 0; i < 30; i++) begin
      m = $urandom_range(2, 0);
      run_pair($sformatf("rnd%0d", i),
               m != 1, 1'($urandom_range(1, 0)), 4'($urandom), rand_adr(), $urandom,
               m != 0, 1'($urandom_range(1, 0)), 4'($urandom), rand_adr(), $urandom);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
